// File: rtl/mem_io_bus_arbiter.sv
// Two-port data-memory/IO bus arbiter: one access at a time, driving a 1-cycle BRAM plus switch/LED IO.
// Optional round-robin contention arbitration is enabled with the ARB_ROUND_ROBIN_EN macro.
module mem_io_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'hFFFF_FC00,
  parameter logic [ADDR_W-1:0] SW_ADR  = 32'hFFFF_FC70,
  parameter logic [ADDR_W-1:0] LED_ADR = 32'hFFFF_FC60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wdat0,
  input  logic [DATA_W-1:0] wdat1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdat,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdat,
  input  logic [DATA_W-1:0] mem_rdat,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                is_io_q, is_io_d;
  logic [ADDR_W-1:2]   adr_q, adr_d;
  logic [15:0]         io_wdat_q, io_wdat_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0]   mem_wdat_q, mem_wdat_d;
  logic [15:0]         led_q, led_d;

  logic                any_req;
  logic                gnt;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_adr;
  logic [DATA_W-1:0]   sel_wdat;

  assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr names the port that wins the next contended grant.
  logic rr_q, rr_d;

  always_comb begin
    gnt  = (req0 && req1) ? rr_q : req1;
    rr_d = rr_q;
    if (state_q == S_IDLE && any_req) rr_d = ~gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  // Loader (port 0) always wins contention.
  always_comb begin
    gnt = ~req0;
  end
`endif

  always_comb begin
    sel_we   = gnt ? we1   : we0;
    sel_adr  = gnt ? adr1  : adr0;
    sel_wdat = gnt ? wdat1 : wdat0;
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    we_d       = we_q;
    is_io_d    = is_io_q;
    adr_d      = adr_q;
    io_wdat_d  = io_wdat_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdat_d     = rdat_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_adr_d  = mem_adr_q;
    mem_wdat_d = mem_wdat_q;
    led_d      = led_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          port_d    = gnt;
          we_d      = sel_we;
          adr_d     = sel_adr[ADDR_W-1:2];
          io_wdat_d = sel_wdat[15:0];
          is_io_d   = (sel_adr >= IO_BASE);
          // BRAM strobes are registered here so they are high throughout ISSUE.
          if (sel_adr < IO_BASE) begin
            mem_en_d   = 1'b1;
            mem_we_d   = sel_we;
            mem_adr_d  = sel_adr[MEM_AW+1:2];
            mem_wdat_d = sel_wdat;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_io_q) begin
          if (we_q) begin
            if (adr_q == LED_ADR[ADDR_W-1:2]) led_d = io_wdat_q;
          end else begin
            rdat_d = '0;
            if (adr_q == SW_ADR[ADDR_W-1:2]) rdat_d[15:0] = sw_in;
          end
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = S_RESP;
        end else if (we_q) begin
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rdat_d  = mem_rdat;
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      is_io_q    <= 1'b0;
      adr_q      <= '0;
      io_wdat_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdat_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      is_io_q    <= is_io_d;
      adr_q      <= adr_d;
      io_wdat_q  <= io_wdat_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdat_q     <= rdat_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_adr_q  <= mem_adr_d;
      mem_wdat_q <= mem_wdat_d;
      led_q      <= led_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdat      = rdat_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdat  = mem_wdat_q;
  assign led_out   = led_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// Self-checking bench for mem_io_bus_arbiter: BRAM model, per-scenario tasks, read-data scoreboard.
module tb_mem_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] adr0 = '0, adr1 = '0;
  logic [31:0] wdat0 = '0, wdat1 = '0;
  logic        ack0, ack1;
  logic [31:0] rdat;
  logic        mem_en, mem_we;
  logic [13:0] mem_adr;
  logic [31:0] mem_wdat;
  logic [31:0] mem_rdat = '0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bram [0:16383];
  logic [31:0] shadow [0:127];

  typedef struct {
    int          lat;
    bit          got;
    int          en_cnt;
    int          we_cnt;
    logic [13:0] seen_adr;
    bit          wrong_ack;
    bit          ack_stuck;
    logic [31:0] exp_rd;
    logic [31:0] obs_rd;
  } obs_t;

  mem_io_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdat0(wdat0), .wdat1(wdat1),
    .ack0(ack0), .ack1(ack1), .rdat(rdat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .sw_in(sw_in), .led_out(led_out), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_adr] <= mem_wdat;
      else        mem_rdat <= bram[mem_adr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver: issues one access on a port, records what the DUT did until the ack.
  task automatic drive_access(input int port, input logic wr, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [31:0] exp_rd, output obs_t o);
    o = '{lat: 0, got: 1'b0, en_cnt: 0, we_cnt: 0, seen_adr: '0, wrong_ack: 1'b0,
          ack_stuck: 1'b0, exp_rd: '0, obs_rd: '0};
    @(negedge clk);
    if (port == 0) begin req0 = 1'b1; we0 = wr; adr0 = adr; wdat0 = wd; end
    else           begin req1 = 1'b1; we1 = wr; adr1 = adr; wdat1 = wd; end
    if (!wr) exp_q.push_back(exp_rd);
    while (!o.got && o.lat < 20) begin
      @(posedge clk); #1;
      o.lat++;
      if (mem_en) begin o.en_cnt++; o.seen_adr = mem_adr; end
      if (mem_we) o.we_cnt++;
      if ((port == 0 && ack1) || (port == 1 && ack0)) o.wrong_ack = 1'b1;
      if ((port == 0) ? ack0 : ack1) o.got = 1'b1;
    end
    o.obs_rd = rdat;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    if (o.got && !wr && exp_q.size() > 0) o.exp_rd = exp_q.pop_front();
    @(posedge clk); #1;
    if (ack0 || ack1 || mem_en) o.ack_stuck = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    checks++;
    if ({ack0, ack1, mem_en, mem_we} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {ack0, ack1, mem_en, mem_we});
    end
    checks++;
    if (rdat !== 32'h0 || mem_wdat !== 32'h0 || mem_adr !== 14'h0) begin
      errors++; $display("FAIL reset_data: rdat=%h mem_wdat=%h mem_adr=%h want 0", rdat, mem_wdat, mem_adr);
    end
    checks++;
    if (led_out !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h want 0000", led_out); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_mem_write();
    obs_t o;
    drive_access(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, o);
    checks++;
    if (!o.got || o.lat != 2) begin errors++; $display("FAIL wr_latency: got=%0d lat=%0d want lat 2", o.got, o.lat); end
    checks++;
    if (o.en_cnt != 1 || o.we_cnt != 1) begin
      errors++; $display("FAIL wr_strobes: en_cycles=%0d we_cycles=%0d want 1/1", o.en_cnt, o.we_cnt);
    end
    checks++;
    if (o.seen_adr !== 14'd4) begin errors++; $display("FAIL wr_mem_adr: got %0d want 4", o.seen_adr); end
    checks++;
    if (o.wrong_ack || o.ack_stuck) begin
      errors++; $display("FAIL wr_ack_pulse: wrong_port=%0d stuck=%0d want 0/0", o.wrong_ack, o.ack_stuck);
    end
  endtask

  task automatic test_mem_read();
    obs_t o;
    drive_access(1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, o);
    checks++;
    if (!o.got || o.lat != 3) begin errors++; $display("FAIL rd_latency: got=%0d lat=%0d want lat 3", o.got, o.lat); end
    checks++;
    if (o.obs_rd !== o.exp_rd) begin errors++; $display("FAIL rd_data: got %h want %h", o.obs_rd, o.exp_rd); end
    checks++;
    if (o.en_cnt != 1 || o.we_cnt != 0 || o.ack_stuck) begin
      errors++; $display("FAIL rd_strobes: en=%0d we=%0d stuck=%0d want 1/0/0", o.en_cnt, o.we_cnt, o.ack_stuck);
    end
  endtask

  task automatic test_led_write();
    obs_t o;
    drive_access(0, 1'b1, 32'hFFFF_FC60, 32'h0000_A5A5, 32'h0, o);
    checks++;
    if (!o.got || o.lat != 2) begin errors++; $display("FAIL led_latency: got=%0d lat=%0d want lat 2", o.got, o.lat); end
    checks++;
    if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_value: got %h want a5a5", led_out); end
    checks++;
    if (o.en_cnt != 0 || o.wrong_ack) begin
      errors++; $display("FAIL led_no_mem: en_cycles=%0d wrong_ack=%0d want 0/0", o.en_cnt, o.wrong_ack);
    end
    // A write to an unmapped IO address must leave the LEDs alone.
    drive_access(1, 1'b1, 32'hFFFF_FC64, 32'h0000_1111, 32'h0, o);
    checks++;
    if (led_out !== 16'hA5A5 || o.lat != 2) begin
      errors++; $display("FAIL io_ignored_write: led=%h lat=%0d want a5a5 lat 2", led_out, o.lat);
    end
  endtask

  task automatic test_switch_read();
    obs_t o;
    sw_in = 16'h1234;
    drive_access(1, 1'b0, 32'hFFFF_FC70, 32'h0, 32'h0000_1234, o);
    checks++;
    if (!o.got || o.lat != 2 || o.en_cnt != 0) begin
      errors++; $display("FAIL sw_latency: got=%0d lat=%0d en=%0d want lat 2 en 0", o.got, o.lat, o.en_cnt);
    end
    checks++;
    if (o.obs_rd !== o.exp_rd) begin errors++; $display("FAIL sw_data: got %h want %h", o.obs_rd, o.exp_rd); end
    drive_access(0, 1'b0, 32'hFFFF_FC80, 32'h0, 32'h0, o);
    checks++;
    if (o.obs_rd !== o.exp_rd || o.lat != 2) begin
      errors++; $display("FAIL io_unmapped_read: got %h lat=%0d want %h lat 2", o.obs_rd, o.lat, o.exp_rd);
    end
    sw_in = 16'hBEEF;
    drive_access(0, 1'b0, 32'hFFFF_FC73, 32'h0, 32'h0000_BEEF, o);
    checks++;
    if (o.obs_rd !== o.exp_rd) begin errors++; $display("FAIL sw_low_bits: got %h want %h", o.obs_rd, o.exp_rd); end
  endtask

  task automatic test_random_mem();
    obs_t o;
    int idx [6];
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      idx[i] = $urandom_range(64, 127);
      d = $urandom;
      shadow[idx[i]] = d;
      drive_access($urandom_range(0, 1), 1'b1, idx[i] * 4, d, 32'h0, o);
      checks++;
      if (!o.got || o.lat != 2 || o.seen_adr !== 14'(idx[i])) begin
        errors++; $display("FAIL rand_wr[%0d]: lat=%0d adr=%0d want lat 2 adr %0d", i, o.lat, o.seen_adr, idx[i]);
      end
    end
    for (int i = 5; i >= 0; i--) begin
      drive_access($urandom_range(0, 1), 1'b0, idx[i] * 4, 32'h0, shadow[idx[i]], o);
      checks++;
      if (!o.got || o.lat != 3 || o.obs_rd !== o.exp_rd) begin
        errors++; $display("FAIL rand_rd[%0d]: lat=%0d got %h want %h", i, o.lat, o.obs_rd, o.exp_rd);
      end
    end
  endtask

  task automatic test_contention();
    int exp_port;
    int port;
    int waited;
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h0000_0100; wdat0 = 32'h1111_0000;
    req1 = 1'b1; we1 = 1'b1; adr1 = 32'h0000_0104; wdat1 = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      port = -1;
      while (port < 0 && waited < 10) begin
        @(posedge clk); #1;
        waited++;
        if (ack0 && ack1) port = 2;
        else if (ack0) port = 0;
        else if (ack1) port = 1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      checks++;
      if (port != exp_port) begin
        errors++; $display("FAIL contention_grant[%0d]: got port %0d want %0d (-1 timeout, 2 both)", i, port, exp_port);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    obs_t o;
    int stray;
    drive_access(1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, o);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h0000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 2'd2) begin errors++; $display("FAIL abort_in_wait: state=%0d want 2", dbg_state); end
    rst = 1'b1;
    req1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ack0 || ack1 || rdat !== 32'h0 || dbg_state !== 2'd0 || mem_en) begin
      errors++; $display("FAIL abort_state: ack=%b rdat=%h state=%0d mem_en=%b want 00/0/0/0",
                         {ack0, ack1}, rdat, dbg_state, mem_en);
    end
    stray = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack0 || ack1) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", stray); end
    drive_access(1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, o);
    checks++;
    if (!o.got || o.lat != 3 || o.obs_rd !== o.exp_rd) begin
      errors++; $display("FAIL abort_recover: lat=%0d got %h want %h", o.lat, o.obs_rd, o.exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_read();
    test_led_write();
    test_switch_read();
    test_random_mem();
    test_contention();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
